// File: rtl/mini_regfile_pkg.sv
// Shared widths, constants and word type for the mini_regfile register file.
package mini_regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef logic [31:0] word_t;

endpackage : mini_regfile_pkg

// File: rtl/mini_regfile_read_port.sv
// One combinational read port: index select, r0 force-to-zero and, when
// REGFILE_BYPASS_EN is defined, same-cycle write-through forwarding.
module rf_read_port
  import mini_regfile_pkg::*;
#(
  parameter int unsigned P_DATA_W   = DATA_W,
  parameter int unsigned P_NUM_REGS = NUM_REGS,
  parameter int unsigned P_ADDR_W   = ADDR_W
) (
  input  logic                  rst,
  input  logic [P_DATA_W-1:0]   regs [P_NUM_REGS],
  input  logic [P_ADDR_W-1:0]   addr,
  input  logic                  reg_write,
  input  logic [P_ADDR_W-1:0]   rd_addr,
  input  logic [P_DATA_W-1:0]   write_data,
  output logic [P_DATA_W-1:0]   data
);

  logic is_zero;

  assign is_zero = (addr == P_ADDR_W'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
  logic fwd_hit;

  // Forward the in-flight write-back; reset reads must see stored contents.
  assign fwd_hit = !rst && reg_write && !is_zero && (rd_addr == addr);

  always_comb begin
    data = regs[addr];
    if (is_zero) begin
      data = '0;
    end else if (fwd_hit) begin
      data = write_data;
    end
  end
`else
  logic unused_wr_ports;

  assign unused_wr_ports = ^{rst, reg_write, rd_addr, write_data};

  always_comb begin
    data = regs[addr];
    if (is_zero) begin
      data = '0;
    end
  end
`endif

endmodule : rf_read_port

// File: rtl/mini_regfile.sv
// KGPminiRISC general-purpose register file: two combinational read ports,
// one clocked write port, r0 hardwired zero. Optional macro: REGFILE_BYPASS_EN.
module mini_regfile
  import mini_regfile_pkg::*;
#(
  parameter int unsigned P_DATA_W   = DATA_W,
  parameter int unsigned P_NUM_REGS = NUM_REGS,
  parameter int unsigned P_ADDR_W   = ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [P_ADDR_W-1:0] rs_addr,
  input  logic [P_ADDR_W-1:0] rt_addr,
  input  logic [P_ADDR_W-1:0] rd_addr,
  input  logic [P_DATA_W-1:0] write_data,
  input  logic                reg_write,
  input  logic [4:0]          shamt,
  input  logic                shamt_sel,
  output logic [P_DATA_W-1:0] rs_data,
  output logic [P_DATA_W-1:0] rt_data,
  output logic [4:0]          shift
);

  logic [P_DATA_W-1:0] regs [P_NUM_REGS];

  // Storage: reset wins over a simultaneous write; writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(P_NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (reg_write && (rd_addr != P_ADDR_W'(ZERO_REG))) begin
      regs[rd_addr] <= write_data;
    end
  end

  rf_read_port #(
    .P_DATA_W   (P_DATA_W),
    .P_NUM_REGS (P_NUM_REGS),
    .P_ADDR_W   (P_ADDR_W)
  ) u_rs_port (
    .rst        (rst),
    .regs       (regs),
    .addr       (rs_addr),
    .reg_write  (reg_write),
    .rd_addr    (rd_addr),
    .write_data (write_data),
    .data       (rs_data)
  );

  rf_read_port #(
    .P_DATA_W   (P_DATA_W),
    .P_NUM_REGS (P_NUM_REGS),
    .P_ADDR_W   (P_ADDR_W)
  ) u_rt_port (
    .rst        (rst),
    .regs       (regs),
    .addr       (rt_addr),
    .reg_write  (reg_write),
    .rd_addr    (rd_addr),
    .write_data (write_data),
    .data       (rt_data)
  );

  // Shift amount follows rt_data (forwarded when bypass is enabled).
  assign shift = shamt_sel ? rt_data[4:0] : shamt;

endmodule : mini_regfile

// File: tb/tb_mini_regfile.sv
// Directed self-checking bench for mini_regfile; covers both REGFILE_BYPASS_EN builds.
module tb_mini_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] write_data;
  logic        reg_write;
  logic [4:0]  shamt;
  logic        shamt_sel;
  logic [31:0] rs_data, rt_data;
  logic [4:0]  shift;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mini_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_addr    (rd_addr),
    .write_data (write_data),
    .reg_write  (reg_write),
    .shamt      (shamt),
    .shamt_sel  (shamt_sel),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .shift      (shift)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; reg_write = 1'b0; rd_addr = 5'd0; write_data = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_v;
    rst = 1'b1; reg_write = 1'b0; rd_addr = 5'd0; write_data = 32'h0;
    rs_addr = 5'd0; rt_addr = 5'd0; shamt = 5'd0; shamt_sel = 1'b0;
    tick();
    #1;
    vectors++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0 || shift !== 5'd0) begin
      errors++;
      $display("FAIL initial_reset: rs=%h rt=%h shift=%0d, required 0/0/0", rs_data, rt_data, shift);
    end
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      reg_write = 1'b1; rd_addr = 5'(i); write_data = 32'h100 + 32'(i);
      tick();
    end
    // Reset with a competing write to r5; stored value still visible this cycle.
    rst = 1'b1; reg_write = 1'b1; rd_addr = 5'd5; write_data = 32'hFFFF_FFFF;
    rs_addr = 5'd5; rt_addr = 5'd31;
    #1;
    vectors++;
    if (rs_data !== 32'h105 || rt_data !== 32'h11F) begin
      errors++;
      $display("FAIL reset_cycle_read: rs=%h rt=%h, required 00000105/0000011f", rs_data, rt_data);
    end
    tick();
    idle();
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      #1;
      exp_v = 32'h0;
      vectors++;
      if (rs_data !== exp_v || rt_data !== exp_v) begin
        errors++;
        $display("FAIL reset_clear r%0d: rs=%h rt=%h, required 0", i, rs_data, rt_data);
      end
    end
  endtask

  task automatic test_basic_rw();
    reg_write = 1'b1; rd_addr = 5'd3; write_data = 32'hDEAD_BEEF;
    tick();
    idle();
    rs_addr = 5'd3; rt_addr = 5'd3;
    #1;
    vectors++;
    if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL basic_rw r3: rs=%h rt=%h, required deadbeef", rs_data, rt_data);
    end
    rs_addr = 5'd4;
    #1;
    vectors++;
    if (rs_data !== 32'h0) begin
      errors++;
      $display("FAIL basic_rw r4: rs=%h, required 0", rs_data);
    end
  endtask

  task automatic test_zero_reg();
    reg_write = 1'b1; rd_addr = 5'd0; write_data = 32'h1234_5678;
    rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    vectors++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg_same_cycle: rs=%h rt=%h, required 0", rs_data, rt_data);
    end
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (rs_data !== 32'h0) begin
        errors++;
        $display("FAIL zero_reg cycle%0d: rs=%h, required 0", c, rs_data);
      end
      tick();
    end
  endtask

  task automatic test_hazard();
    logic [31:0] exp_same;
    reg_write = 1'b1; rd_addr = 5'd7; write_data = 32'h1;
    tick();
    reg_write = 1'b1; rd_addr = 5'd7; write_data = 32'h2;
    rs_addr = 5'd7; rt_addr = 5'd7;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h2;
`else
    exp_same = 32'h1;
`endif
    #1;
    vectors++;
    if (rs_data !== exp_same || rt_data !== exp_same) begin
      errors++;
      $display("FAIL hazard_same_cycle: rs=%h rt=%h, required %h", rs_data, rt_data, exp_same);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rs_data !== 32'h2) begin
      errors++;
      $display("FAIL hazard_next_cycle: rs=%h, required 2", rs_data);
    end
  endtask

  task automatic test_shift_sel();
    logic [4:0] exp_fwd;
    reg_write = 1'b1; rd_addr = 5'd9; write_data = 32'h0000_00F3;
    tick();
    idle();
    rt_addr = 5'd9; shamt = 5'd4; shamt_sel = 1'b1;
    #1;
    vectors++;
    if (shift !== 5'd19) begin
      errors++;
      $display("FAIL shift_from_rt: shift=%0d, required 19", shift);
    end
    shamt_sel = 1'b0;
    #1;
    vectors++;
    if (shift !== 5'd4) begin
      errors++;
      $display("FAIL shift_from_shamt: shift=%0d, required 4", shift);
    end
    // r10 is still 0 from reset; a same-cycle write only reaches shift via bypass.
    reg_write = 1'b1; rd_addr = 5'd10; write_data = 32'h0000_003E;
    rt_addr = 5'd10; shamt_sel = 1'b1;
`ifdef REGFILE_BYPASS_EN
    exp_fwd = 5'd30;
`else
    exp_fwd = 5'd0;
`endif
    #1;
    vectors++;
    if (shift !== exp_fwd) begin
      errors++;
      $display("FAIL shift_same_cycle_write: shift=%0d, required %0d", shift, exp_fwd);
    end
    tick();
    idle();
    shamt_sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_n1;
    reg_write = 1'b1; rd_addr = 5'd2; write_data = 32'hA;
    rs_addr = 5'd2; rt_addr = 5'd1;
    tick();
    reg_write = 1'b1; rd_addr = 5'd2; write_data = 32'hB;
`ifdef REGFILE_BYPASS_EN
    exp_n1 = 32'hB;
`else
    exp_n1 = 32'hA;
`endif
    #1;
    vectors++;
    if (rs_data !== exp_n1) begin
      errors++;
      $display("FAIL back_to_back n+1: rs=%h, required %h", rs_data, exp_n1);
    end
    tick();
    idle();
    rt_addr = 5'd2;
    #1;
    vectors++;
    if (rs_data !== 32'hB || rt_data !== 32'hB) begin
      errors++;
      $display("FAIL back_to_back n+2: rs=%h rt=%h, required b", rs_data, rt_data);
    end
    rs_addr = 5'd3;
    #1;
    vectors++;
    if (rs_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL back_to_back r3_intact: rs=%h, required deadbeef", rs_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_zero_reg();
    test_hazard();
    test_shift_sel();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_mini_regfile

// File: doc/mini_regfile.md
Name: mini_regfile

Overview:
- General-purpose register file for the KGPminiRISC datapath. It sits directly upstream of the ALU.
- Supplies the two ALU source operands (a = rs, b = rt) and the 5-bit shift amount.
- Accepts the write-back result (ALU result or load data) on the following clock edge.
- Register 0 is hardwired zero.
- Storage is clocked. Reads are combinational.

Parameters:
- DATA_W, 32, register and operand width in bits.
- NUM_REGS, 32, number of architectural registers (power of two).
- ADDR_W, 5, register index width; must equal log2(NUM_REGS).

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rs_addr  input  ADDR_W  read port A index (ALU operand a).
- rt_addr  input  ADDR_W  read port B index (ALU operand b).
- rd_addr  input  ADDR_W  write port index.
- write_data  input  DATA_W  write-back value.
- reg_write  input  1  write enable, sampled at the clock edge.
- shamt  input  5  immediate shift amount from the instruction.
- shamt_sel  input  1  shift source select: 0 = shamt, 1 = rt_data[4:0].
- rs_data  output  DATA_W  read port A data.
- rt_data  output  DATA_W  read port B data.
- shift  output  5  shift amount to ALU.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high. Ports are named clk and rst.
- Reset:
  - On a rising edge with rst=1, all NUM_REGS registers become 0, regardless of reg_write.
  - rst has priority over a simultaneous write.
  - After reset: rs_data=0, rt_data=0, shift = shamt or 0 according to shamt_sel.
- Write:
  - On a rising edge with rst=0, reg_write=1 and rd_addr!=0, regs[rd_addr] <= write_data.
  - Latency is 1 cycle; the value is visible on reads from the next cycle.
  - Writes with rd_addr=0 are discarded. Writes with reg_write=0 change nothing.
- Read:
  - Purely combinational: rs_data = regs[rs_addr], rt_data = regs[rt_addr].
  - Index 0 always returns 0.
  - Both ports may address the same register; both return identical data.
- Shift mux: shift = shamt_sel ? rt_data[4:0] : shamt. Combinational, with no extra latency.
- Same-cycle read/write to the same nonzero index: behaviour is set by the optional feature below.
- No x-propagation: every register has a defined value after the first reset edge.
- No handshake: the write is single-cycle fire-and-forget, and the port accepts one write per cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding. If reg_write=1, rd_addr!=0 and rd_addr matches rs_addr (or rt_addr), that port outputs write_data combinationally in the same cycle.
  - The shift mux sees the forwarded rt_data.
  - rst=1 suppresses forwarding; reads return stored values.
- Not defined: reads return the stored (old) value until the write edge. The hazard is left to the pipeline.

Decomposition:
- Shared package holds:
  - DATA_W, ADDR_W and NUM_REGS defaults.
  - ZERO_REG = 5'd0.
  - A 32-bit word typedef, reused by the ALU operand and result types.
- One natural sub-module: rf_read_port, instantiated twice. It does index select, the zero-register force and the optional bypass compare/mux.
- The storage array and write logic stay in mini_regfile.

Test Plan:
- Reset clear: write distinct values to r1..r31, assert rst for 1 cycle with reg_write=1, rd_addr=5, write_data=32'hFFFF_FFFF -> every register reads 0, including r5.
- Basic write/read: write r3=32'hDEAD_BEEF, next cycle rs_addr=3, rt_addr=3 -> both ports 32'hDEAD_BEEF. rs_addr=4 -> 0.
- Zero register: reg_write=1, rd_addr=0, write_data=32'h1234_5678 -> rs_addr=0 reads 0 in all following cycles.
- Same-cycle hazard: r7 holds 32'h1, same cycle write r7=32'h2 with rs_addr=7:
  - With REGFILE_BYPASS_EN: rs_data=32'h2 that cycle.
  - Without it: 32'h1 that cycle, 32'h2 next.
- Shift select: r9=32'h0000_00F3, rt_addr=9.
  - shamt_sel=1 -> shift=5'd19.
  - shamt_sel=0, shamt=5'd4 -> shift=5'd4.
- Back-to-back writes: write r2=32'hA on cycle n, r2=32'hB on n+1 -> read 32'hA at n+1, 32'hB at n+2. No lost or duplicated updates.
